// File: rtl/aes_pkg.sv
// Shared AES key-expansion definitions: key-size constants, Nk/Nr helpers,
// GF(2^8) xtime, the schedule word type and the expander FSM states.
package aes_pkg;

    localparam int AES_KEY_128 = 128;
    localparam int AES_KEY_192 = 192;
    localparam int AES_KEY_256 = 256;

    typedef logic [31:0] aes_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_DRAIN = 2'd2
    } aes_state_e;

    function automatic int aes_nk(input int key_bits);
        return key_bits >> 5;
    endfunction

    function automatic int aes_nr(input int key_bits);
        return aes_nk(key_bits) + 6;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: one byte in, one byte out, purely combinational.
module aes_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    // Entry 0 sits in the top byte; ~x * 8 is the bit offset of entry x.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX_TABLE[{~x, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key expander, one schedule word per cycle, round keys
// streamed over valid/ready. Define AES_KEY_EXPAND_INV_EN to emit keys in decryption order.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_data,
    output logic [3:0]          rk_index,
    output logic                rk_last
);

    localparam int NK = aes_nk(KEY_BITS);
    localparam int NR = aes_nr(KEY_BITS);
    localparam int NW = 4 * (NR + 1);
    localparam logic [5:0] NK_I   = 6'(NK);
    localparam logic [5:0] NW_I   = 6'(NW);
    localparam logic [5:0] LAST_I = 6'(NW - 1);
    localparam logic [3:0] NR_IDX = 4'(NR);
    localparam logic [2:0] PH_MAX = 3'(NK - 1);

    aes_state_e state_q, state_d;
    aes_word_t  hist_q [NK];
    aes_word_t  asm0_q, asm1_q, asm2_q;
    logic [5:0] i_q;
    logic [2:0] phase_q;
    logic [7:0] rcon_q;

    aes_word_t temp, sub_in, sub_out, temp_x, w_new;
    logic [127:0] key_word;
    logic key_done, gen_adv, accept;

    // SubWord on RotWord(temp) at phase 0, on temp itself otherwise
    assign temp   = hist_q[NK-1];
    assign sub_in = (phase_q == 3'd0) ? {temp[23:0], temp[31:24]} : temp;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .x (sub_in[8*b +: 8]),
            .y (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        temp_x = temp;
        if (phase_q == 3'd0) begin
            temp_x = sub_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && phase_q == 3'd4) begin
            temp_x = sub_out;
        end
        w_new = (i_q < NK_I) ? hist_q[0] : (hist_q[0] ^ temp_x);
    end

    assign key_done = (i_q[1:0] == 2'b11);
    assign key_word = {asm0_q, asm1_q, asm2_q, w_new};
    assign accept   = rk_valid && rk_ready;
    assign busy     = (state_q != ST_IDLE);

`ifdef AES_KEY_EXPAND_INV_EN
    logic [127:0] store_q [NR+1];
    logic [3:0]   drain_idx;
    logic         drain_load;

    assign gen_adv    = (state_q == ST_GEN);
    assign drain_idx  = rk_valid ? 4'(rk_index - 4'd1) : NR_IDX;
    assign drain_load = (state_q == ST_DRAIN) && (!rk_valid || (rk_ready && !rk_last));

    always_ff @(posedge clk) begin
        if (gen_adv && key_done) begin
            store_q[i_q[5:2]] <= key_word;
        end
    end
`else
    logic out_free;

    // The 4th word may only advance when the output register can take the key
    assign out_free = !rk_valid || rk_ready;
    assign gen_adv  = (state_q == ST_GEN) && (i_q != NW_I) && (!key_done || out_free);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_GEN;
`ifdef AES_KEY_EXPAND_INV_EN
            ST_GEN:   if (i_q == LAST_I) state_d = ST_DRAIN;
            ST_DRAIN: if (accept && rk_last) state_d = ST_IDLE;
`else
            ST_GEN:   if (accept && rk_last) state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            i_q      <= '0;
            phase_q  <= '0;
            rcon_q   <= 8'h01;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_index <= '0;
            rk_last  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                i_q     <= '0;
                phase_q <= '0;
                rcon_q  <= 8'h01;
            end else if (gen_adv) begin
                i_q     <= i_q + 6'd1;
                phase_q <= (phase_q == PH_MAX) ? 3'd0 : phase_q + 3'd1;
                if (i_q >= NK_I && phase_q == 3'd0) begin
                    rcon_q <= xtime(rcon_q);
                end
            end
`ifdef AES_KEY_EXPAND_INV_EN
            if (drain_load) begin
                rk_valid <= 1'b1;
                rk_data  <= store_q[drain_idx];
                rk_index <= drain_idx;
                rk_last  <= (drain_idx == 4'd0);
            end else if (rk_ready) begin
                rk_valid <= 1'b0;
            end
`else
            if (gen_adv && key_done) begin
                rk_valid <= 1'b1;
                rk_data  <= key_word;
                rk_index <= i_q[5:2];
                rk_last  <= (i_q[5:2] == NR_IDX);
            end else if (rk_ready) begin
                rk_valid <= 1'b0;
            end
`endif
        end
    end

    // History buffer: oldest word at index 0, newest (w[i-1]) at NK-1
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && start) begin
            for (int j = 0; j < NK; j++) begin
                hist_q[j] <= key_in[KEY_BITS-1-32*j -: 32];
            end
        end else if (gen_adv) begin
            for (int j = 0; j < NK - 1; j++) begin
                hist_q[j] <= hist_q[j+1];
            end
            hist_q[NK-1] <= w_new;
            case (i_q[1:0])
                2'd0:    asm0_q <= w_new;
                2'd1:    asm1_q <= w_new;
                2'd2:    asm2_q <= w_new;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq: AES-128/192/256 instances against a
// GF(2^8)-derived reference schedule, with random keys and random backpressure.
module tb_aes_key_expand_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start    [3];
    logic         rk_ready [3];
    logic         busy     [3];
    logic         rk_valid [3];
    logic [127:0] rk_data  [3];
    logic [3:0]   rk_index [3];
    logic         rk_last  [3];
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;

    aes_key_expand_seq #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .rst(rst), .start(start[0]), .key_in(key128), .busy(busy[0]),
        .rk_valid(rk_valid[0]), .rk_ready(rk_ready[0]), .rk_data(rk_data[0]),
        .rk_index(rk_index[0]), .rk_last(rk_last[0]));

    aes_key_expand_seq #(.KEY_BITS(192)) u_dut192 (
        .clk(clk), .rst(rst), .start(start[1]), .key_in(key192), .busy(busy[1]),
        .rk_valid(rk_valid[1]), .rk_ready(rk_ready[1]), .rk_data(rk_data[1]),
        .rk_index(rk_index[1]), .rk_last(rk_last[1]));

    aes_key_expand_seq #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .rst(rst), .start(start[2]), .key_in(key256), .busy(busy[2]),
        .rk_valid(rk_valid[2]), .rk_ready(rk_ready[2]), .rk_data(rk_data[2]),
        .rk_index(rk_index[2]), .rk_last(rk_last[2]));

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [15];
    logic [127:0] got    [15];

    localparam logic [255:0] KEY_V128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] KEY_V192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY_V256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        return (v << s) | (v >> (8 - s));
    endfunction

    // S-box from first principles: multiplicative inverse then affine map
    task automatic init_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr = nk + 6;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[32*(nk-1-i) +: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    rc = 8'h01;
                    for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r < 15; r++) begin
            exp_rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
        end
    endtask

    task automatic set_key(input int k, input logic [255:0] key);
        if (k == 0) key128 = key[127:0];
        else if (k == 1) key192 = key[191:0];
        else key256 = key;
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Start one expansion on instance k and consume every key it emits.
    // mode 0: rk_ready held high; mode 1: rk_ready low for 0-20 cycles before each accept.
    task automatic run_seq(input int k, input logic [255:0] key, input int mode,
                           input bit glitch, input bit check_timing);
        int nk = 4 + 2 * k;
        int nr = nk + 6;
        int nw = 4 * (nr + 1);
        int n = 0;
        int cnt = 0;
        int lowcnt = 0;
        int exp_r;
        int first_edge, last_edge;
        bit held = 0;
        bit ready;
        logic [127:0] h_data;
        logic [3:0]   h_index;
        logic         h_last;
`ifdef AES_KEY_EXPAND_INV_EN
        first_edge = nw + 1;
        last_edge  = nw + 1 + nr;
`else
        first_edge = 4;
        last_edge  = nw;
`endif
        model_expand(key, nk);
        for (int r = 0; r < 15; r++) got[r] = '0;
        if (mode == 1) lowcnt = $urandom_range(0, 20);
        set_key(k, key);
        start[k]    = 1'b1;
        rk_ready[k] = 1'b0;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        set_key(k, rand_key());
        while (cnt <= nr && n < 3000) begin
            @(posedge clk);
            n++;
            #1;
            start[k] = (glitch && n == 9);
            if (glitch && n == 9) set_key(k, rand_key());
            if (held) begin
                n_tests++;
                if (rk_valid[k] !== 1'b1 || rk_data[k] !== h_data ||
                    rk_index[k] !== h_index || rk_last[k] !== h_last) begin
                    n_fail++;
                    $display("FAIL stall_hold k%0d edge %0d: got v%b idx%0d last%b %h, required held idx%0d last%b %h",
                             k, n, rk_valid[k], rk_index[k], rk_last[k], rk_data[k], h_index, h_last, h_data);
                end
            end
            if (mode == 0) ready = 1'b1;
            else if (lowcnt > 0) begin ready = 1'b0; lowcnt--; end
            else ready = 1'b1;
            rk_ready[k] = ready;
            held = 0;
            if (rk_valid[k] === 1'b1) begin
                if (ready) begin
`ifdef AES_KEY_EXPAND_INV_EN
                    exp_r = nr - cnt;
`else
                    exp_r = cnt;
`endif
                    n_tests++;
                    if (rk_data[k] !== exp_rk[exp_r] || rk_index[k] !== 4'(exp_r) ||
                        rk_last[k] !== (cnt == nr)) begin
                        n_fail++;
                        $display("FAIL key k%0d #%0d: got idx%0d last%b %h, required idx%0d last%b %h",
                                 k, cnt, rk_index[k], rk_last[k], rk_data[k], exp_r, (cnt == nr), exp_rk[exp_r]);
                    end
                    got[exp_r] = rk_data[k];
                    if (check_timing && (cnt == 0 || cnt == nr)) begin
                        n_tests++;
                        if (n != ((cnt == 0) ? first_edge : last_edge)) begin
                            n_fail++;
                            $display("FAIL latency k%0d #%0d: valid after edge %0d, required edge %0d",
                                     k, cnt, n, (cnt == 0) ? first_edge : last_edge);
                        end
                    end
                    cnt++;
                    if (mode == 1) lowcnt = $urandom_range(0, 20);
                end else begin
                    held    = 1;
                    h_data  = rk_data[k];
                    h_index = rk_index[k];
                    h_last  = rk_last[k];
                end
            end
        end
        start[k] = 1'b0;
        n_tests++;
        if (cnt <= nr) begin
            n_fail++;
            $display("FAIL timeout k%0d: got %0d keys, required %0d", k, cnt, nr + 1);
        end else begin
            @(posedge clk);
            #1;
            if (busy[k] !== 1'b0 || rk_valid[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_end k%0d: got busy %b valid %b, required 0 0", k, busy[k], rk_valid[k]);
            end
        end
        rk_ready[k] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name, input int k);
        n_tests++;
        if (busy[k] !== 1'b0 || rk_valid[k] !== 1'b0 || rk_data[k] !== 128'h0 ||
            rk_index[k] !== 4'h0 || rk_last[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s k%0d: got busy%b v%b idx%0d last%b %h, required all zero",
                     name, k, busy[k], rk_valid[k], rk_index[k], rk_last[k], rk_data[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start[k]    = 1'b0;
            rk_ready[k] = 1'b0;
        end
        key128 = '0; key192 = '0; key256 = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_zero("reset", k);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_aes128_vector();
        run_seq(0, KEY_V128, 0, 0, 1);
        n_tests++;
        if (got[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            n_fail++;
            $display("FAIL vec128_idx1: got %h, required a0fafe1788542cb123a339392a6c7605", got[1]);
        end
        n_tests++;
        if (got[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_fail++;
            $display("FAIL vec128_idx10: got %h, required d014f9a8c9ee2589e13f0cc8b6630ca6", got[10]);
        end
        n_tests++;
        if (got[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
            n_fail++;
            $display("FAIL vec128_idx0: got %h, required 2b7e151628aed2a6abf7158809cf4f3c", got[0]);
        end
    endtask

    task automatic test_aes192_vector();
        run_seq(1, KEY_V192, 0, 0, 1);
        n_tests++;
        if (got[12] !== 128'he98ba06f448c773c8ecc720401002202) begin
            n_fail++;
            $display("FAIL vec192_idx12: got %h, required e98ba06f448c773c8ecc720401002202", got[12]);
        end
    endtask

    task automatic test_aes256_vector();
        run_seq(2, KEY_V256, 0, 0, 1);
        n_tests++;
        if (got[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            n_fail++;
            $display("FAIL vec256_idx14: got %h, required fe4890d1e6188d0b046df344706c631e", got[14]);
        end
    endtask

    task automatic test_random_keys();
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 3; k++) run_seq(k, rand_key(), 0, 0, 1);
        end
    endtask

    task automatic test_backpressure();
        run_seq(0, KEY_V128, 1, 0, 0);
        for (int k = 0; k < 3; k++) run_seq(k, rand_key(), 1, 0, 0);
    endtask

    task automatic test_start_while_busy();
        run_seq(0, KEY_V128, 0, 1, 1);
        run_seq(2, rand_key(), 1, 1, 0);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        set_key(0, KEY_V128);
        start[0]    = 1'b1;
        rk_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        while (!(rk_valid[0] === 1'b1 && rk_index[0] === 4'd4) && n < 200) begin
            @(posedge clk);
            n++;
            #1;
        end
        n_tests++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL reset_mid_wait: index 4 never seen, required within 200 cycles");
        end
        rst      = 1'b1;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        start[0] = 1'b0;
        check_zero("reset_mid", 0);
        @(posedge clk);
        #1;
        check_zero("reset_over_start", 0);
        rk_ready[0] = 1'b0;
        run_seq(0, KEY_V128, 0, 0, 1);
    endtask

    initial begin
        init_sbox();
        test_reset();
        test_aes128_vector();
        test_aes192_vector();
        test_aes256_vector();
        test_random_keys();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
